// File: rtl/btn_event_pkg.sv
// btn_event_pkg: shared types, default codes and sizing helper
// for the button event generator.
package btn_event_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    REPEAT
  } state_t;

  localparam logic [7:0] PRESS_CODE_DEF   = 8'h50;
  localparam logic [7:0] LONG_CODE_DEF    = 8'h4C;
  localparam logic [7:0] REPEAT_CODE_DEF  = 8'h52;
  localparam logic [7:0] RELEASE_CODE_DEF = 8'h55;

  function automatic int cnt_width(
    input int a,
    input int b
  );
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/btn_event_if.sv
// btn_event_if: valid/ready byte channel toward the UART TX FIFO.
// master drives valid/data, slave returns ready.
interface btn_event_if;

  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_data;

  modport master (
    output evt_valid,
    output evt_data,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_data,
    output evt_ready
  );

endinterface

// File: rtl/btn_event_outreg.sv
// btn_event_outreg: one-entry holding register; an emit that finds
// the entry full and not draining is dropped with a drop pulse.
module btn_event_outreg
  import btn_event_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       emit,
  input  logic [7:0] code,
  output logic       drop,
  btn_event_if.master evt
);

  logic xfer;

  assign xfer = evt.evt_valid & evt.evt_ready;

  // load on emit when free or draining, else flag a drop
  always_ff @(posedge clk) begin
    if (reset) begin
      evt.evt_valid <= 1'b0;
      evt.evt_data  <= 8'h00;
      drop          <= 1'b0;
    end else begin
      drop <= 1'b0;
      if (emit) begin
        if (!evt.evt_valid || xfer) begin
          evt.evt_valid <= 1'b1;
          evt.evt_data  <= code;
        end else begin
          drop <= 1'b1;
        end
      end else if (xfer) begin
        evt.evt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/btn_event_gen.sv
// btn_event_gen: press / long / repeat key events from a debounced
// level; define BTN_RELEASE_EVT_EN to also emit a release event.
module btn_event_gen
  import btn_event_pkg::*;
#(
  parameter int unsigned LONG_CNT     = 100_000_000,
  parameter int unsigned REPEAT_CNT   = 20_000_000,
  parameter logic [7:0]  PRESS_CODE   = PRESS_CODE_DEF,
  parameter logic [7:0]  LONG_CODE    = LONG_CODE_DEF,
  parameter logic [7:0]  REPEAT_CODE  = REPEAT_CODE_DEF,
  parameter logic [7:0]  RELEASE_CODE = RELEASE_CODE_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic debounce,
  output logic evt_drop,
  output logic pressed,
  btn_event_if.master evt
);

  localparam int CW = cnt_width(LONG_CNT, REPEAT_CNT);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CNT - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CNT - 1);

`ifdef BTN_RELEASE_EVT_EN
  localparam bit REL_EN = 1'b1;
`else
  localparam bit REL_EN = 1'b0;
`endif

  state_t        state;
  logic [CW-1:0] cnt;
  logic          prev;
  logic          rise;
  logic          emit;
  logic [7:0]    code;

  assign rise    = debounce & ~prev;
  assign pressed = prev;

  // event decision; release takes priority over timer expiry
  always_comb begin
    emit = 1'b0;
    code = PRESS_CODE;
    unique case (state)
      IDLE: begin
        if (rise) begin
          emit = 1'b1;
          code = PRESS_CODE;
        end
      end
      PRESS: begin
        if (!debounce) begin
          emit = REL_EN;
          code = RELEASE_CODE;
        end else if (cnt == LONG_LAST) begin
          emit = 1'b1;
          code = LONG_CODE;
        end
      end
      REPEAT: begin
        if (!debounce) begin
          emit = REL_EN;
          code = RELEASE_CODE;
        end else if (cnt == REP_LAST) begin
          emit = 1'b1;
          code = REPEAT_CODE;
        end
      end
      default: begin
        emit = 1'b0;
      end
    endcase
  end

  // state, hold timer and edge history; never stalls on backpressure
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      prev  <= 1'b1;
    end else begin
      prev <= debounce;
      unique case (state)
        IDLE: begin
          if (rise) begin
            cnt   <= '0;
            state <= PRESS;
          end
        end
        PRESS: begin
          if (!debounce) begin
            state <= IDLE;
          end else if (cnt == LONG_LAST) begin
            cnt   <= '0;
            state <= REPEAT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        REPEAT: begin
          if (!debounce) begin
            state <= IDLE;
          end else if (cnt == REP_LAST) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  btn_event_outreg u_outreg (
    .clk   (clk),
    .reset (reset),
    .emit  (emit),
    .code  (code),
    .drop  (evt_drop),
    .evt   (evt)
  );

endmodule
